// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_pkg: shared timing defaults, derived-timing helpers, config states |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package vga_pkg;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;
  localparam int c_CW       = 10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } cfg_state_t;

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  // Exclusive end: the pulse covers [sync_start, sync_end).
  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_ctrl_seleccion_timing_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_timing_cnt: h/v pixel counters gated by pix_en, end-of-frame flag  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module vga_timing_cnt #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pix_en,
  output logic [CW-1:0] o_hc,
  output logic [CW-1:0] o_vc,
  output logic          o_eof
);

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_hc == CW'(H_TOTAL - 1));
  assign w_v_last = (r_vc == CW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (i_pix_en) begin
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  // High on the clock edge that wraps the position back to (0,0).
  assign o_eof = i_pix_en && w_h_last && w_v_last;
  assign o_hc  = r_hc;
  assign o_vc  = r_vc;

endmodule
`default_nettype wire

// File: rtl/vga_ctrl_seleccion.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_ctrl_seleccion: VGA timing with frame-synchronous selection window |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module vga_ctrl_seleccion
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int H_FP     = c_H_FP,
  parameter int H_SYNC   = c_H_SYNC,
  parameter int H_BP     = c_H_BP,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int V_FP     = c_V_FP,
  parameter int V_SYNC   = c_V_SYNC,
  parameter int V_BP     = c_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = c_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pix_en,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [CW-1:0] i_cfg_x0,
  input  logic [CW-1:0] i_cfg_x1,
  input  logic [CW-1:0] i_cfg_y0,
  input  logic [CW-1:0] i_cfg_y1,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic [CW-1:0] o_pix_x,
  output logic [CW-1:0] o_pix_y,
  output logic          o_seleccion_color,
  output logic          o_frame_start
);

  localparam int            c_H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int            c_V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_HS_START = CW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] c_HS_END   = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] c_VS_START = CW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] c_VS_END   = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [CW-1:0] w_hc;
  logic [CW-1:0] w_vc;
  logic          w_eof;

  vga_timing_cnt #(
    .H_TOTAL (c_H_TOTAL),
    .V_TOTAL (c_V_TOTAL),
    .CW      (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_pix_en (i_pix_en),
    .o_hc     (w_hc),
    .o_vc     (w_vc),
    .o_eof    (w_eof)
  );

  cfg_state_t    r_state;
  cfg_state_t    w_state_nxt;
  logic          w_load_pend;
  logic          w_commit;
  logic [CW-1:0] r_pend_x0, r_pend_x1, r_pend_y0, r_pend_y1;
  logic [CW-1:0] r_win_x0, r_win_x1, r_win_y0, r_win_y1;

  always_comb begin
    w_state_nxt = r_state;
    w_load_pend = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (i_cfg_valid) begin
        w_load_pend = 1'b1;
        w_state_nxt = S_PEND;
      end
      S_PEND: if (w_eof) begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset window has x0>x1 and y0>y1, so nothing is selected until configured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend_x0 <= CW'(1);
      r_pend_x1 <= '0;
      r_pend_y0 <= CW'(1);
      r_pend_y1 <= '0;
      r_win_x0  <= CW'(1);
      r_win_x1  <= '0;
      r_win_y0  <= CW'(1);
      r_win_y1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_pend) begin
        r_pend_x0 <= i_cfg_x0;
        r_pend_x1 <= i_cfg_x1;
        r_pend_y0 <= i_cfg_y0;
        r_pend_y1 <= i_cfg_y1;
      end
      if (w_commit) begin
        r_win_x0 <= r_pend_x0;
        r_win_x1 <= r_pend_x1;
        r_win_y0 <= r_pend_y0;
        r_win_y1 <= r_pend_y1;
      end
    end
  end

  assign o_cfg_ready = (r_state == S_IDLE);

  logic w_video;
  logic w_hs_act;
  logic w_vs_act;
  logic w_sel;

  assign w_video  = (w_hc < c_H_ACT) && (w_vc < c_V_ACT);
  assign w_hs_act = (w_hc >= c_HS_START) && (w_hc < c_HS_END);
  assign w_vs_act = (w_vc >= c_VS_START) && (w_vc < c_VS_END);
  assign w_sel    = w_video && (w_hc >= r_win_x0) && (w_hc <= r_win_x1)
                            && (w_vc >= r_win_y0) && (w_vc <= r_win_y1);

  logic          r_hsync, r_vsync, r_video_on, r_sel, r_frame_start;
  logic [CW-1:0] r_pix_x, r_pix_y;

  // Single output register keeps position, syncs and selection aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_sel         <= 1'b0;
      r_frame_start <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
    end else begin
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video;
      r_sel         <= w_sel;
      r_frame_start <= (w_hc == '0) && (w_vc == '0) && i_pix_en;
      r_pix_x       <= w_hc;
      r_pix_y       <= w_vc;
    end
  end

  assign o_hsync           = r_hsync;
  assign o_vsync           = r_vsync;
  assign o_video_on        = r_video_on;
  assign o_seleccion_color = r_sel;
  assign o_frame_start     = r_frame_start;
  assign o_pix_x           = r_pix_x;
  assign o_pix_y           = r_pix_y;

endmodule
`default_nettype wire

// File: doc/vga_ctrl_seleccion.md
Name: vga_ctrl_seleccion

Overview:
Pixel-timing controller that drives the colour selector of the VGA output path. It generates the horizontal and vertical counters, the hsync/vsync pulses and the active-video flag. It also produces the one-bit seleccion_color: asserted inside a programmable rectangular window during active video, deasserted elsewhere. Window coordinates come in through a valid/ready handshake and are applied only at frame boundaries, so the window never tears mid-frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, width of counters and coordinates

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel strobe; counters advance only on clk edges where pix_en=1
cfg_valid  in  1  window update offered
cfg_ready  out  1  controller can accept a window update
cfg_x0  in  CW  window left column, inclusive
cfg_x1  in  CW  window right column, inclusive
cfg_y0  in  CW  window top line, inclusive
cfg_y1  in  CW  window bottom line, inclusive
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
video_on  out  1  current pixel is inside the active area
pix_x  out  CW  current column
pix_y  out  CW  current line
seleccion_color  out  1  1 = foreground colour, 0 = background colour
frame_start  out  1  one-clk pulse when the pixel position becomes (0,0)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - hc=vc=0, so pix_x=pix_y=0.
  - hsync=vsync=~SYNC_POL.
  - video_on=0, seleccion_color=0, frame_start=0.
  - cfg_ready=1, pend=0.
  - Active window empty (x0=1, x1=0, y0=1, y1=0).
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Counters: on clk with pix_en=1, hc increments.
  - hc==H_TOTAL-1 wraps to 0 and vc increments.
  - vc==V_TOTAL-1 at the line wrap returns to 0.
  - pix_en=0 holds all counter state.
- Output stage: one register, one clk latency. All outputs are computed combinationally from the current hc/vc and registered together, so pix_x/pix_y, syncs, video_on and seleccion_color are always mutually aligned.
  - video_on = (hc<H_ACTIVE) && (vc<V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; ~SYNC_POL otherwise.
  - vsync uses the same rule with the V_* parameters applied to vc.
  - seleccion_color = video_on && x0<=hc<=x1 && y0<=vc<=y1.
  - x0>x1 or y0>y1 gives an empty window (never asserted).
  - Windows extending past the active area are clipped by video_on.
  - frame_start = registered (hc==0 && vc==0 && pix_en).
- Config FSM, two states:
  - IDLE: cfg_ready=1. cfg_valid=1 latches cfg_* into the pending registers and moves to PEND.
  - PEND: cfg_ready=0. cfg_valid is ignored. On the counter wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), pending values are copied into the active window and the FSM returns to IDLE.
  - The new window takes effect from pixel (0,0) of the next frame.
  - Handshake in IDLE on the same clk as the frame wrap: the update is accepted into pending and committed at the following frame wrap, not the current one.
- rst mid-frame or while in PEND: pending data is discarded and all reset values apply on the next clk.

Decomposition:
- Package vga_pkg holds:
  - default timing constants;
  - the derived H_TOTAL/V_TOTAL and sync start/end functions;
  - the CW default;
  - the config FSM state encoding (IDLE, PEND).
- One sub-module, vga_timing_cnt, holds the h/v counters with pix_en, the wrap logic and an end_of_frame strobe.
- The top level holds the config FSM, the window compare and the output register.

Test Plan:
All scenarios use reduced timing: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0, pix_en=1 constantly.
1. Reset then free-run: hsync=0 exactly when registered pix_x in {10,11}; vsync=0 for line 5 only; video_on=1 for x<8, y<4; frame_start pulses every 14*7=98 clks; seleccion_color stays 0 (empty window).
2. Window (x0=2, x1=4, y0=1, y1=2) sent mid-frame: cfg_ready drops the next clk; the current frame shows no selection; the next frame shows seleccion_color=1 only at x in 2..4, y in 1..2 (6 pixels); cfg_ready returns to 1 after the wrap.
3. cfg_valid held high in PEND with other values (x0=0, x1=7): ignored; the first accepted window stays active.
4. Handshake on the exact frame-wrap clk: the window is not applied in the frame that starts immediately; it is applied one frame later.
5. pix_en toggling 1/0: counters and outputs hold during pix_en=0; frame period doubles to 196 clks.
6. rst asserted at pixel (5,2) while in PEND: the next clk shows pix_x=pix_y=0, hsync=vsync=1, video_on=0, cfg_ready=1; the window remains empty after the next frame wrap.
